// File: rtl/riscv_if_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package riscv_if_pkg;

    localparam int          INSTR_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // IDLE: PC follows normal priority; PEND: a redirect arrived while PC was stalled
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > wrong-path squash > load.
// A faulting fetch is delivered as a valid, marked NOP rather than a bubble.
module if_id_reg
    import riscv_if_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic               stall,
    input  logic               flush,
    input  logic               squash,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [31:0]        fetch_pc,
    input  logic               fetch_fault,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               valid,
    output logic               fault
);

    logic [INSTR_W-1:0] instr_reg;
    logic [31:0]        pc_reg;
    logic [31:0]        pc_plus4_reg;
    logic               valid_reg;
    logic               fault_reg;

    // Register update; a bubble is NOP with zero PCs and both flags low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_reg    <= NOP_INSTR;
            pc_reg       <= 32'h0;
            pc_plus4_reg <= 32'h0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
        end else if (flush) begin
            instr_reg    <= NOP_INSTR;
            pc_reg       <= 32'h0;
            pc_plus4_reg <= 32'h0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
        end else if (stall) begin
            instr_reg    <= instr_reg;
            pc_reg       <= pc_reg;
            pc_plus4_reg <= pc_plus4_reg;
            valid_reg    <= valid_reg;
            fault_reg    <= fault_reg;
        end else if (squash) begin
            instr_reg    <= NOP_INSTR;
            pc_reg       <= 32'h0;
            pc_plus4_reg <= 32'h0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            instr_reg    <= fetch_fault ? NOP_INSTR : fetch_instr;
            pc_reg       <= fetch_pc;
            pc_plus4_reg <= fetch_pc + 32'd4;
            valid_reg    <= 1'b1;
            fault_reg    <= fetch_fault;
        end
    end

    assign instr    = instr_reg;
    assign pc       = pc_reg;
    assign pc_plus4 = pc_plus4_reg;
    assign valid    = valid_reg;
    assign fault    = fault_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC register, stalled-redirect tracking, fetch fault check,
// and the IF/ID register feeding decode.
module if_fetch_stage
    import riscv_if_pkg::*;
#(
    parameter logic [31:0]        RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR,
    parameter int                 IMEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [31:0]        PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD,
    output logic               FaultD
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0]  pc_reg;
    logic [31:0]  pend_target_reg;
    fetch_state_t state_reg;
    logic         fetch_fault;
    logic         squash;

    // Misaligned or beyond the end of instruction memory
    assign fetch_fault = (pc_reg[1:0] != 2'b00) || ({2'b00, pc_reg[31:2]} >= IMEM_LIMIT);

    // Anything fetched while a redirect is in flight is on the wrong path
    assign squash = PCSrcE || (state_reg == PEND);

    // Next-PC selection and redirect bookkeeping while the PC is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            pend_target_reg <= 32'h0;
            state_reg       <= IDLE;
        end else if (PCSrcE && !StallF) begin
            pc_reg    <= PCTargetE;
            state_reg <= IDLE;       // a fresh redirect supersedes any pending one
        end else if ((state_reg == PEND) && !StallF) begin
            pc_reg    <= pend_target_reg;
            state_reg <= IDLE;
        end else if (StallF) begin
            if (PCSrcE) begin
                pend_target_reg <= PCTargetE;   // latest redirect wins
                state_reg       <= PEND;
            end
        end else begin
            pc_reg <= pc_reg + 32'd4;           // wraps modulo 2^32
        end
    end

    assign PCF = pc_reg;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (StallD),
        .flush       (FlushD),
        .squash      (squash),
        .fetch_instr (InstrF),
        .fetch_pc    (pc_reg),
        .fetch_fault (fetch_fault),
        .instr       (InstrD),
        .pc          (PCD),
        .pc_plus4    (PCPlus4D),
        .valid       (ValidD),
        .fault       (FaultD)
    );

endmodule
